cpu_ctrl_seq: RTL and testbench
===============================

# cpu_ctrl_seq

Instruction sequencer for the 8-bit CPU datapath. It accepts 16-bit micro-instructions over a valid/ready handshake and decodes each one. It then generates the cycle-accurate register strobes, ALU controls and databus drive that the A/B register file and ALU consume. Read and ALU results are returned on a response port.

## Interface
- DATA_W, 8: databus and immediate width; only 8 is supported.
- RECOVER_CYC, 1: idle cycles inserted after every instruction, legal range 0..3.

- i_pld_clk  in  1  single clock, all logic rising-edge.
- i_pld_rst  in  1  reset: one clock; reset is synchronous and active-high.
- i_instr  in  16  micro-instruction with fields:
  - [15:13] op: 000 NOP, 001 LDA, 010 LDB, 011 RDA, 100 RDB, 101 ALU, 11x illegal.
  - [12] cin.
  - [11:8] alu opcode.
  - [7:0] immediate.
- i_instr_valid  in  1  instruction present.
- o_instr_ready  out  1  sequencer can accept.
- o_a_wrtn, o_b_wrtn  out  1 each  active-low register write strobes.
- o_a_rdn, o_b_rdn  out  1 each  active-low register read enables.
- o_alu_opcode  out  4  ALU operation.
- o_cin  out  1  ALU carry-in.
- o_alu_sel, o_alu_flag_sel  out  1 each  ALU result / flag drive enables onto the bus.
- o_data  out  8  databus drive value.
- o_data_oe  out  1  databus output enable; top level builds the tristate.
- i_data  in  8  databus sampled value.
- o_rsp_data  out  8  captured read/ALU result.
- o_rsp_valid  out  1  one-cycle result pulse.
- o_err  out  1  sticky illegal-op flag, only when the feature is enabled.

## Operation
- All outputs are registered.
- Reset values:
  - wrtn/rdn = 1; sel, flag_sel, oe, cin, rsp_valid, err = 0.
  - alu_opcode, data, rsp_data = 0.
  - State = IDLE; o_instr_ready = 0 while i_pld_rst is high.
- FSM states: IDLE, ACT1, ACT2, ACT3, RECOVER.
- o_instr_ready = 1 only in IDLE. An instruction is accepted when valid && ready, and its fields are latched at that point.
- LDA/LDB:
  - ACT1: oe = 1, data = imm.
  - ACT2: the selected wrtn = 0.
  - ACT3: wrtn = 1, oe still 1.
- RDA/RDB:
  - ACT1–ACT2: the selected rdn = 0.
  - i_data is sampled at the end of ACT1.
  - ACT2: rsp_valid = 1 with the sample.
  - ACT3: rdn = 1.
- ALU:
  - ACT1: alu_opcode and cin are loaded; sel = flag_sel = 1 during ACT1–ACT2.
  - Sample and response timing are identical to RD.
  - ACT3: sel = flag_sel = 0.
  - alu_opcode and cin hold their value until the next ALU op.
- NOP: goes ACT1 → RECOVER with no strobes.
- Illegal op: handled as NOP.
- RECOVER lasts RECOVER_CYC cycles; with 0 it is skipped and the FSM returns to IDLE.
- Only one strobe group is ever active at a time. oe is never high while any rdn is low or sel is high.
- Reset mid-instruction: at the next edge all outputs take their reset values, the latched instruction is discarded and no rsp_valid is issued.
- i_instr_valid while busy is ignored (not accepted); the instruction must be held until ready.

## Timing
- Accept at edge E0 → ACT1 is the cycle after E0.
- Busy cycles:
  - LD/RD/ALU: 3 + RECOVER_CYC busy cycles, so the accept-to-accept period is 4 + RECOVER_CYC (5 by default).
  - NOP/illegal: period 2 + RECOVER_CYC.
- Result latency: rsp_valid occurs 2 cycles after the accept edge.
- First accept is possible in the first cycle after i_pld_rst deasserts.

## Configuration
- CPU_CTRL_ERR_EN defined:
  - An illegal op sets o_err at ACT1.
  - o_err stays high until i_pld_rst.
- CPU_CTRL_ERR_EN undefined:
  - o_err is tied 0.
  - Illegal ops are silent NOPs with identical timing.

## Structure
- Package cpu_ctrl_pkg holds:
  - Op enum and instruction field bit positions.
  - FSM state enum.
  - The RECOVER_CYC legal-range constant.
- One sub-module, cpu_ctrl_decode: combinational mapping from the latched op to the strobe-select / uses-bus / returns-result flags. The FSM and registers stay in cpu_ctrl_seq.

## Test plan
- Reset → all outputs at reset values, ready=0. Deassert reset → ready=1 next cycle.
- LDA imm 0x5A (i_instr 0x205A) → oe=1/data=0x5A for 3 cycles; a_wrtn low only in the middle cycle; ready returns 5 cycles after accept.
- RDB with i_data=0xC3 → b_rdn low 2 cycles; rsp_valid one cycle with rsp_data=0xC3, 2 cycles after accept; oe=0 throughout.
- ALU op 0x3, cin=1 (i_instr 0xB300) with bus 0x7F → alu_opcode=3, cin=1, sel/flag_sel high 2 cycles; rsp_data=0x7F; opcode held afterwards.
- i_instr 0xE000 with CPU_CTRL_ERR_EN → o_err rises and sticks; next LDB 0x4411 executes normally. Without the macro, o_err stays 0.
- Reset asserted during LDB ACT2 → b_wrtn=1 and oe=0 the next cycle; no rsp_valid. Valid held during busy → accepted only in IDLE.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the cpu_ctrl_seq micro-instruction sequencer.
// Optional feature macro: CPU_CTRL_ERR_EN (sticky illegal-op flag on o_err).
package cpu_ctrl_pkg;

    // Micro-instruction field positions
    localparam int unsigned OpMsb  = 15;
    localparam int unsigned OpLsb  = 13;
    localparam int unsigned CinBit = 12;
    localparam int unsigned AluMsb = 11;
    localparam int unsigned AluLsb = 8;
    localparam int unsigned ImmMsb = 7;
    localparam int unsigned ImmLsb = 0;

    // Largest supported number of recovery cycles after an instruction
    localparam int unsigned RecoverCycMax = 3;

    typedef enum logic [2:0] {
        OpNop  = 3'b000,
        OpLda  = 3'b001,
        OpLdb  = 3'b010,
        OpRda  = 3'b011,
        OpRdb  = 3'b100,
        OpAlu  = 3'b101,
        OpIll6 = 3'b110,
        OpIll7 = 3'b111
    } op_e;

    // FSM encoding kept as plain constants for legacy tool compatibility
    typedef logic [2:0] state_t;
    localparam state_t StIdle    = 3'd0;
    localparam state_t StAct1    = 3'd1;
    localparam state_t StAct2    = 3'd2;
    localparam state_t StAct3    = 3'd3;
    localparam state_t StRecover = 3'd4;

    // Per-op control flags produced by the decoder
    typedef struct packed {
        logic sel_b;          // target register B rather than A
        logic drives_bus;     // load: immediate is driven onto the databus
        logic reads_reg;      // register read enable is used
        logic returns_result; // a response is captured from the bus
        logic is_alu;         // ALU result/flag drive
        logic illegal;        // reserved op encoding
    } dec_t;

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational op decoder for cpu_ctrl_seq: maps an op to strobe-select and bus flags.
module cpu_ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  op_e  op_i,
    output dec_t dec_o
);

    // Each legal op enables exactly one strobe group
    always_comb begin
        dec_o = '0;
        unique case (op_i)
            OpNop: ;
            OpLda: dec_o.drives_bus = 1'b1;
            OpLdb: begin
                dec_o.drives_bus = 1'b1;
                dec_o.sel_b      = 1'b1;
            end
            OpRda: begin
                dec_o.reads_reg      = 1'b1;
                dec_o.returns_result = 1'b1;
            end
            OpRdb: begin
                dec_o.reads_reg      = 1'b1;
                dec_o.returns_result = 1'b1;
                dec_o.sel_b          = 1'b1;
            end
            OpAlu: begin
                dec_o.is_alu         = 1'b1;
                dec_o.returns_result = 1'b1;
            end
            OpIll6, OpIll7: dec_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Micro-instruction sequencer driving the A/B register file, ALU and databus.
// Every output is registered; strobes are computed from the next FSM state.
// Optional feature macro: CPU_CTRL_ERR_EN (sticky illegal-op flag on o_err).
// RECOVER_CYC must lie in 0..RecoverCycMax.
module cpu_ctrl_seq
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned RECOVER_CYC = 1
) (
    input  logic              i_pld_clk,
    input  logic              i_pld_rst,
    input  logic [15:0]       i_instr,
    input  logic              i_instr_valid,
    output logic              o_instr_ready,
    output logic              o_a_wrtn,
    output logic              o_b_wrtn,
    output logic              o_a_rdn,
    output logic              o_b_rdn,
    output logic [3:0]        o_alu_opcode,
    output logic              o_cin,
    output logic              o_alu_sel,
    output logic              o_alu_flag_sel,
    output logic [DATA_W-1:0] o_data,
    output logic              o_data_oe,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic              o_rsp_valid,
    output logic              o_err
);

    state_t            state_q, state_d;
    logic [1:0]        rec_cnt_q, rec_cnt_d;
    op_e               op_q, op_d;
    logic              ready_q, ready_d;
    logic              a_wrtn_q, a_wrtn_d, b_wrtn_q, b_wrtn_d;
    logic              a_rdn_q, a_rdn_d, b_rdn_q, b_rdn_d;
    logic [3:0]        alu_opcode_q, alu_opcode_d;
    logic              cin_q, cin_d;
    logic              sel_q, sel_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              oe_q, oe_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_valid_q, rsp_valid_d;

    logic accept;
    logic rec_last;
    logic act12, act123;
    dec_t dec;

    assign accept   = (state_q == StIdle) && ready_q && i_instr_valid;
    // Last recovery cycle once the counter has covered RECOVER_CYC cycles
    assign rec_last = ({30'd0, rec_cnt_q} + 32'd1) >= RECOVER_CYC;

    // Op is latched at accept; the decoder sees the value valid for the next cycle
    always_comb begin
        op_d = op_q;
        if (accept) begin
            op_d = op_e'(i_instr[OpMsb:OpLsb]);
        end
    end

    cpu_ctrl_decode u_decode (
        .op_i  (op_d),
        .dec_o (dec)
    );

    // Next-state logic: ACT1..ACT3 for bus ops, ACT1 only for NOP/illegal, then RECOVER
    always_comb begin
        state_d   = state_q;
        rec_cnt_d = rec_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StAct1;
                end
            end
            StAct1: begin
                if (dec.drives_bus || dec.returns_result) begin
                    state_d = StAct2;
                end else begin
                    state_d   = (RECOVER_CYC == 0) ? StIdle : StRecover;
                    rec_cnt_d = 2'd0;
                end
            end
            StAct2: state_d = StAct3;
            StAct3: begin
                state_d   = (RECOVER_CYC == 0) ? StIdle : StRecover;
                rec_cnt_d = 2'd0;
            end
            StRecover: begin
                if (rec_last) begin
                    state_d = StIdle;
                end else begin
                    rec_cnt_d = rec_cnt_q + 2'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output next values derived from the state about to be entered
    always_comb begin
        act12  = (state_d == StAct1) || (state_d == StAct2);
        act123 = act12 || (state_d == StAct3);

        ready_d  = (state_d == StIdle);
        a_wrtn_d = !((state_d == StAct2) && dec.drives_bus && !dec.sel_b);
        b_wrtn_d = !((state_d == StAct2) && dec.drives_bus && dec.sel_b);
        a_rdn_d  = !(act12 && dec.reads_reg && !dec.sel_b);
        b_rdn_d  = !(act12 && dec.reads_reg && dec.sel_b);
        oe_d     = act123 && dec.drives_bus;
        sel_d    = act12 && dec.is_alu;

        data_d = data_q;
        if (accept && dec.drives_bus) begin
            data_d = i_instr[ImmMsb:ImmLsb];
        end

        // ALU controls persist until the next ALU op
        alu_opcode_d = alu_opcode_q;
        cin_d        = cin_q;
        if (accept && dec.is_alu) begin
            alu_opcode_d = i_instr[AluMsb:AluLsb];
            cin_d        = i_instr[CinBit];
        end

        // Bus is sampled at the end of ACT1 and presented during ACT2
        rsp_valid_d = (state_q == StAct1) && (state_d == StAct2) && dec.returns_result;
        rsp_data_d  = rsp_valid_d ? i_data : rsp_data_q;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge i_pld_clk) begin
        if (i_pld_rst) begin
            state_q      <= StIdle;
            rec_cnt_q    <= 2'd0;
            op_q         <= OpNop;
            ready_q      <= 1'b0;
            a_wrtn_q     <= 1'b1;
            b_wrtn_q     <= 1'b1;
            a_rdn_q      <= 1'b1;
            b_rdn_q      <= 1'b1;
            alu_opcode_q <= 4'd0;
            cin_q        <= 1'b0;
            sel_q        <= 1'b0;
            data_q       <= '0;
            oe_q         <= 1'b0;
            rsp_data_q   <= '0;
            rsp_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rec_cnt_q    <= rec_cnt_d;
            op_q         <= op_d;
            ready_q      <= ready_d;
            a_wrtn_q     <= a_wrtn_d;
            b_wrtn_q     <= b_wrtn_d;
            a_rdn_q      <= a_rdn_d;
            b_rdn_q      <= b_rdn_d;
            alu_opcode_q <= alu_opcode_d;
            cin_q        <= cin_d;
            sel_q        <= sel_d;
            data_q       <= data_d;
            oe_q         <= oe_d;
            rsp_data_q   <= rsp_data_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

`ifdef CPU_CTRL_ERR_EN
    logic err_q, err_d;

    // Sticky illegal-op flag, visible from ACT1 of the offending op
    always_comb begin
        err_d = err_q | (accept & dec.illegal);
    end

    // Error flag register, cleared only by reset
    always_ff @(posedge i_pld_clk) begin
        if (i_pld_rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign o_err = err_q;
`else
    logic unused_illegal;
    assign unused_illegal = dec.illegal;
    assign o_err          = 1'b0;
`endif

    assign o_instr_ready  = ready_q;
    assign o_a_wrtn       = a_wrtn_q;
    assign o_b_wrtn       = b_wrtn_q;
    assign o_a_rdn        = a_rdn_q;
    assign o_b_rdn        = b_rdn_q;
    assign o_alu_opcode   = alu_opcode_q;
    assign o_cin          = cin_q;
    assign o_alu_sel      = sel_q;
    assign o_alu_flag_sel = sel_q;
    assign o_data         = data_q;
    assign o_data_oe      = oe_q;
    assign o_rsp_data     = rsp_data_q;
    assign o_rsp_valid    = rsp_valid_q;

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Self-checking bench for cpu_ctrl_seq: timeline reference model plus response scoreboard.
module tb_cpu_ctrl_seq;

    localparam int unsigned RC = 1;
    localparam int NA   = 4096;
    localparam int NRND = 2500;

    logic        i_pld_clk = 1'b0;
    logic        i_pld_rst;
    logic [15:0] i_instr;
    logic        i_instr_valid;
    logic        o_instr_ready;
    logic        o_a_wrtn, o_b_wrtn, o_a_rdn, o_b_rdn;
    logic [3:0]  o_alu_opcode;
    logic        o_cin, o_alu_sel, o_alu_flag_sel;
    logic [7:0]  o_data;
    logic        o_data_oe;
    logic [7:0]  i_data;
    logic [7:0]  o_rsp_data;
    logic        o_rsp_valid;
    logic        o_err;

    cpu_ctrl_seq #(
        .DATA_W      (8),
        .RECOVER_CYC (RC)
    ) dut (
        .i_pld_clk      (i_pld_clk),
        .i_pld_rst      (i_pld_rst),
        .i_instr        (i_instr),
        .i_instr_valid  (i_instr_valid),
        .o_instr_ready  (o_instr_ready),
        .o_a_wrtn       (o_a_wrtn),
        .o_b_wrtn       (o_b_wrtn),
        .o_a_rdn        (o_a_rdn),
        .o_b_rdn        (o_b_rdn),
        .o_alu_opcode   (o_alu_opcode),
        .o_cin          (o_cin),
        .o_alu_sel      (o_alu_sel),
        .o_alu_flag_sel (o_alu_flag_sel),
        .o_data         (o_data),
        .o_data_oe      (o_data_oe),
        .i_data         (i_data),
        .o_rsp_data     (o_rsp_data),
        .o_rsp_valid    (o_rsp_valid),
        .o_err          (o_err)
    );

    always #5 i_pld_clk = ~i_pld_clk;

    // cyc = number of rising edges so far; cycle n is the interval after edge n
    int cyc = 0;
    always @(posedge i_pld_clk) cyc <= cyc + 1;

    // Expected per-cycle outputs (timeline written by the model when inputs are issued)
    bit         ex_ready [NA];
    bit         ex_awr [NA], ex_bwr [NA], ex_ard [NA], ex_brd [NA];
    bit         ex_oe [NA], ex_sel [NA], ex_cin [NA], ex_err [NA];
    logic [7:0] ex_data [NA], ex_rsp [NA];
    logic [3:0] ex_alu [NA];

    typedef struct {
        int         tag;
        logic [7:0] d;
    } rsp_t;
    rsp_t rsp_q[$];

    int  vec_cnt = 0;
    int  err_cnt = 0;
    int  next_edge = 1;
    int  pend = -1;   // edge at which a read/ALU result is sampled
    bit  mon_en = 1'b0;
    bit  unused_acc;

    task automatic chk(input string name, input int act, input int exp);
        vec_cnt++;
        if (act != exp) begin
            err_cnt++;
            if (err_cnt <= 40)
                $display("FAIL %s cycle %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: applies the inputs seen at edge e to the expected timeline
    task automatic model(input int e, input logic r, input logic v, input logic [15:0] ins,
                         input logic [7:0] d, output bit acc);
        logic [2:0] op;
        int         period;
        acc = 1'b0;
        if (r) begin
            for (int c = e; c < NA; c++) begin
                ex_ready[c] = (c != e);
                ex_awr[c] = 1; ex_bwr[c] = 1; ex_ard[c] = 1; ex_brd[c] = 1;
                ex_oe[c] = 0; ex_sel[c] = 0; ex_cin[c] = 0; ex_err[c] = 0;
                ex_data[c] = 8'h00; ex_rsp[c] = 8'h00; ex_alu[c] = 4'h0;
            end
            while (rsp_q.size() > 0 && rsp_q[$].tag >= e) void'(rsp_q.pop_back());
            pend = -1;
        end else begin
            if (pend == e) begin
                rsp_q.push_back('{e, d});
                for (int c = e; c < NA; c++) ex_rsp[c] = d;
                pend = -1;
            end
            if (v && e >= 1 && ex_ready[e-1]) begin
                acc    = 1'b1;
                op     = ins[15:13];
                period = (op >= 3'd1 && op <= 3'd5) ? 4 + int'(RC) : 2 + int'(RC);
                for (int c = e; c <= e + period - 2; c++) ex_ready[c] = 0;
                case (op)
                    3'd1, 3'd2: begin
                        for (int c = e; c <= e + 2; c++) ex_oe[c] = 1;
                        for (int c = e; c < NA; c++) ex_data[c] = ins[7:0];
                        if (op == 3'd1) ex_awr[e+1] = 0;
                        else ex_bwr[e+1] = 0;
                    end
                    3'd3: begin ex_ard[e] = 0; ex_ard[e+1] = 0; pend = e + 1; end
                    3'd4: begin ex_brd[e] = 0; ex_brd[e+1] = 0; pend = e + 1; end
                    3'd5: begin
                        ex_sel[e] = 1; ex_sel[e+1] = 1;
                        for (int c = e; c < NA; c++) begin
                            ex_alu[c] = ins[11:8];
                            ex_cin[c] = ins[12];
                        end
                        pend = e + 1;
                    end
                    3'd6, 3'd7: begin
`ifdef CPU_CTRL_ERR_EN
                        for (int c = e; c < NA; c++) ex_err[c] = 1;
`endif
                    end
                    default: ;
                endcase
            end
        end
    endtask

    // Drive inputs for the next edge, record them in the model, advance one cycle
    task automatic apply(input logic r, input logic v, input logic [15:0] ins,
                         input logic [7:0] d, output bit acc);
        i_pld_rst     = r;
        i_instr_valid = v;
        i_instr       = ins;
        i_data        = d;
        model(next_edge, r, v, ins, d, acc);
        @(posedge i_pld_clk);
        #1;
        next_edge++;
    endtask

    // Hold an instruction valid until the model says it is accepted
    task automatic send(input logic [15:0] ins, input logic [7:0] d);
        bit acc;
        int tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 16) begin
            apply(1'b0, 1'b1, ins, d, acc);
            tries++;
        end
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    // Monitor: compare every output each cycle, pop the scoreboard on rsp_valid
    always @(negedge i_pld_clk) begin
        if (mon_en && cyc >= 1 && cyc < NA) begin
            bit expv;
            chk("ready", int'(o_instr_ready), int'(ex_ready[cyc]));
            chk("a_wrtn", int'(o_a_wrtn), int'(ex_awr[cyc]));
            chk("b_wrtn", int'(o_b_wrtn), int'(ex_bwr[cyc]));
            chk("a_rdn", int'(o_a_rdn), int'(ex_ard[cyc]));
            chk("b_rdn", int'(o_b_rdn), int'(ex_brd[cyc]));
            chk("data_oe", int'(o_data_oe), int'(ex_oe[cyc]));
            chk("data", int'(o_data), int'(ex_data[cyc]));
            chk("alu_sel", int'(o_alu_sel), int'(ex_sel[cyc]));
            chk("alu_flag_sel", int'(o_alu_flag_sel), int'(ex_sel[cyc]));
            chk("alu_opcode", int'(o_alu_opcode), int'(ex_alu[cyc]));
            chk("cin", int'(o_cin), int'(ex_cin[cyc]));
            chk("err", int'(o_err), int'(ex_err[cyc]));
            chk("rsp_data_hold", int'(o_rsp_data), int'(ex_rsp[cyc]));
            expv = (rsp_q.size() > 0) && (rsp_q[0].tag == cyc);
            chk("rsp_valid", int'(o_rsp_valid), int'(expv));
            if (expv) begin
                rsp_t r;
                r = rsp_q.pop_front();
                if (o_rsp_valid) chk("rsp_data", int'(o_rsp_data), int'(r.d));
            end
        end
    end

    initial begin
        for (int c = 0; c < NA; c++) begin
            ex_ready[c] = 0;
            ex_awr[c] = 1; ex_bwr[c] = 1; ex_ard[c] = 1; ex_brd[c] = 1;
            ex_oe[c] = 0; ex_sel[c] = 0; ex_cin[c] = 0; ex_err[c] = 0;
            ex_data[c] = 8'h00; ex_rsp[c] = 8'h00; ex_alu[c] = 4'h0;
        end
        mon_en = 1'b1;

        // Reset, then the directed scenarios
        apply(1'b1, 1'b0, 16'h0000, 8'h00, unused_acc);
        apply(1'b1, 1'b0, 16'h0000, 8'h00, unused_acc);
        send(16'h205A, 8'h00);                        // LDA 0x5A
        send(16'h8000, 8'hC3);                        // RDB, held valid while busy
        apply(1'b0, 1'b0, 16'h0000, 8'hC3, unused_acc);
        send(16'hB300, 8'h7F);                        // ALU op 3, cin 1
        apply(1'b0, 1'b0, 16'h0000, 8'h7F, unused_acc);
        send(16'h0000, 8'h00);                        // NOP
        send(16'hE000, 8'h00);                        // illegal
        send(16'h4411, 8'h00);                        // LDB 0x11
        send(16'h4422, 8'h00);                        // LDB, reset during ACT2
        apply(1'b0, 1'b0, 16'h0000, 8'h00, unused_acc);
        apply(1'b1, 1'b0, 16'h0000, 8'h00, unused_acc);
        apply(1'b0, 1'b0, 16'h0000, 8'h00, unused_acc);
        send(16'h6000, 8'h99);                        // RDA, reset during ACT1
        apply(1'b1, 1'b0, 16'h0000, 8'h99, unused_acc);
        send(16'hA5F0, 8'h3C);                        // ALU op 5, cin 0
        apply(1'b0, 1'b0, 16'h0000, 8'h3C, unused_acc);

        // Randomized traffic
        for (int i = 0; i < NRND; i++) begin
            logic       r, v;
            logic [15:0] ins;
            logic [7:0] d;
            r   = ($urandom_range(0, 79) == 0);
            v   = ($urandom_range(0, 9) < 6);
            ins = 16'($urandom);
            d   = 8'($urandom);
            apply(r, v, ins, d, unused_acc);
        end

        for (int i = 0; i < 12; i++) apply(1'b0, 1'b0, 16'h0000, 8'h00, unused_acc);
        mon_en = 1'b0;
        chk("rsp_leftover", rsp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
